// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline interlock.
//   mul_state_e : multiplier sequencer states (IDLE, START, BUSY, DONE)
//   sb_entry_t  : one scoreboard entry {valid, destination reg, mul flag}
//   REG_ZERO    : hard-wired zero register, never a hazard source
//   src_match   : true when an in-use, non-zero source hits a valid entry
package hazard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } mul_state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       mul;
  } sb_entry_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam sb_entry_t  SB_EMPTY = '{valid: 1'b0, rd: 5'd0, mul: 1'b0};

  // Scoreboard slot indices, youngest first
  localparam int SB_EX    = 0;
  localparam int SB_MEM   = 1;
  localparam int SB_WB    = 2;
  localparam int SB_DEPTH = 3;

  function automatic logic src_match(input logic use_src, input logic [4:0] src,
                                     input sb_entry_t e);
    return use_src && (src != REG_ZERO) && e.valid && (e.rd == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mul_sequencer.sv
// mul_sequencer: starts the multicycle multiplier when a MUL sits in EX and
// holds EX until the product is ready or the timeout expires.
//   CLK, RST  : clock, synchronous active-low reset
//   ex_mul    : the EX scoreboard entry is a MUL
//   mul_done  : multiplier finished (only honoured in BUSY)
//   ex_hold   : freeze EX while the MUL is being sequenced
//   mul_start : one-cycle start pulse
//   mul_err   : sticky timeout flag, cleared only by reset
module mul_sequencer
  import hazard_pkg::*;
#(
  parameter int MUL_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic CLK,
  input  logic RST,
  input  logic ex_mul,
  input  logic mul_done,
  output logic ex_hold,
  output logic mul_start,
  output logic mul_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

  mul_state_e       state_r, state_nxt_s;
  logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
  logic             err_r, err_nxt_s;
  logic             hold_s, start_s;

  // State, timeout counter and sticky error registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Next-state, counter and hold/start decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    err_nxt_s   = err_r;
    hold_s      = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (ex_mul) begin
          hold_s      = 1'b1;
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        hold_s      = 1'b1;
        start_s     = 1'b1;
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = BUSY;
      end
      BUSY: begin
        hold_s    = 1'b1;
        cnt_nxt_s = cnt_r + CNT_W'(1);
        if (mul_done) begin
          state_nxt_s = DONE;
        end else if (cnt_r == CNT_LAST) begin
          // Forced exit: the product is abandoned and the error latched
          state_nxt_s = DONE;
          err_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      DONE: begin
        // EX/MEM captures the product this cycle; EX is released
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Outputs forced low while reset is asserted
  assign ex_hold   = hold_s & RST;
  assign mul_start = start_s & RST;
  assign mul_err   = err_r & RST;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW interlock and multiplier sequencing for the 5-stage core.
//   CLK, RST                 : clock, synchronous active-low reset
//   id_valid                 : ID holds a real instruction
//   id_rs/id_rt, id_use_*    : ID source registers and their use flags
//   id_wr_en, id_wr_reg      : ID destination write enable and register
//   id_is_mul                : ID instruction is a MUL
//   mul_done                 : multiplier finished
//   stall_if                 : hold PC and IF/ID
//   bubble                   : zero control into ID/EX
//   ex_hold                  : hold ID/EX and multiplier operands, bubble EX/MEM
//   mul_start, mul_err       : multiplier start pulse, sticky timeout flag
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WB_BYPASS   = 0,
  parameter int MUL_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       id_wr_en,
  input  logic [4:0] id_wr_reg,
  input  logic       id_is_mul,
  input  logic       mul_done,
  output logic       stall_if,
  output logic       bubble,
  output logic       ex_hold,
  output logic       mul_start,
  output logic       mul_err
);

  // A write-first register file makes the WB slot invisible to ID
  localparam bit CHK_WB = (WB_BYPASS == 0);

  sb_entry_t sb_r [SB_DEPTH];
  sb_entry_t ex_new_s;
  logic      hazard_s;
  logic      ex_hold_s;

  mul_sequencer #(
    .MUL_TIMEOUT (MUL_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_mul_seq (
    .CLK       (CLK),
    .RST       (RST),
    .ex_mul    (sb_r[SB_EX].mul),
    .mul_done  (mul_done),
    .ex_hold   (ex_hold_s),
    .mul_start (mul_start),
    .mul_err   (mul_err)
  );

  // RAW comparison of both ID sources against the tracked destinations
  always_comb begin
    hazard_s = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      hazard_s = hazard_s
               | ((src_match(id_use_rs, id_rs, sb_r[i]) | src_match(id_use_rt, id_rt, sb_r[i]))
                  & ((i != SB_WB) | CHK_WB));
    end
    hazard_s = hazard_s & id_valid & RST;
  end

  assign stall_if = hazard_s | ex_hold_s;
  assign bubble   = hazard_s & ~ex_hold_s;
  assign ex_hold  = ex_hold_s;

  // Entry that ID would push into EX this cycle
  always_comb begin
    ex_new_s = SB_EMPTY;
    if (bubble) begin
      ex_new_s = SB_EMPTY;
    end else begin
      ex_new_s.valid = id_valid & id_wr_en;
      ex_new_s.rd    = id_wr_reg;
      ex_new_s.mul   = id_valid & id_is_mul;
    end
  end

  // Scoreboard shift; during a hold EX is frozen and MEM takes a bubble
  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        sb_r[i] <= SB_EMPTY;
      end
    end else if (ex_hold_s) begin
      sb_r[SB_MEM] <= SB_EMPTY;
      sb_r[SB_WB]  <= sb_r[SB_MEM];
    end else begin
      sb_r[SB_EX]  <= ex_new_s;
      sb_r[SB_MEM] <= sb_r[SB_EX];
      sb_r[SB_WB]  <= sb_r[SB_MEM];
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random stimulus for hazard_ctrl, checked every
// cycle against a reference model that tracks in-flight writers by pipeline
// position and the MUL by how many cycles it has occupied EX.
module tb_hazard_ctrl;

  localparam int TB_WB_BYPASS = 0;
  localparam int TB_TIMEOUT   = 40;

  logic       CLK, RST;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_mul, mul_done;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       stall_if, bubble, ex_hold, mul_start, mul_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_rd [3];      // destination in EX/MEM/WB, -1 = no writer
  bit m_ex_mul;      // EX holds a MUL
  int m_age;         // cycles that MUL has spent in EX so far
  bit m_mul_fin;     // this cycle is the MUL's final (release) cycle
  bit m_err;
  bit last_stall;

  int n_stall, n_bub, n_hold, n_start;

  hazard_ctrl #(
    .WB_BYPASS   (TB_WB_BYPASS),
    .MUL_TIMEOUT (TB_TIMEOUT),
    .CNT_W       (6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .id_wr_en  (id_wr_en),
    .id_wr_reg (id_wr_reg),
    .id_is_mul (id_is_mul),
    .mul_done  (mul_done),
    .stall_if  (stall_if),
    .bubble    (bubble),
    .ex_hold   (ex_hold),
    .mul_start (mul_start),
    .mul_err   (mul_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_n(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit m_hazard();
    bit h = 1'b0;
    if (!id_valid) return 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (s == 2 && TB_WB_BYPASS != 0) continue;
      if (m_rd[s] < 0) continue;
      if (id_use_rs && id_rs != 5'd0 && m_rd[s] == int'(id_rs)) h = 1'b1;
      if (id_use_rt && id_rt != 5'd0 && m_rd[s] == int'(id_rt)) h = 1'b1;
    end
    return h;
  endfunction

  task automatic m_clear();
    for (int s = 0; s < 3; s++) m_rd[s] = -1;
    m_ex_mul  = 1'b0;
    m_age     = 0;
    m_mul_fin = 1'b0;
    m_err     = 1'b0;
  endtask

  task automatic clr_cnt();
    n_stall = 0; n_bub = 0; n_hold = 0; n_start = 0;
  endtask

  // One clock: check mid-cycle, then advance the model at the edge
  task automatic tick();
    bit e_haz, e_hold, e_stall, e_bub, e_start, e_err;
    #4;
    e_hold  = RST && m_ex_mul && !m_mul_fin;
    e_haz   = RST && m_hazard();
    e_stall = e_haz || e_hold;
    e_bub   = e_haz && !e_hold;
    e_start = RST && m_ex_mul && (m_age == 1);
    e_err   = RST && m_err;
    chk("stall_if", stall_if, e_stall);
    chk("bubble", bubble, e_bub);
    chk("ex_hold", ex_hold, e_hold);
    chk("mul_start", mul_start, e_start);
    chk("mul_err", mul_err, e_err);
    n_stall += int'(stall_if);
    n_bub   += int'(bubble);
    n_hold  += int'(ex_hold);
    n_start += int'(mul_start);
    last_stall = e_stall;
    @(posedge CLK);
    if (!RST) begin
      m_clear();
    end else begin
      if (m_ex_mul && !m_mul_fin) begin
        // Ages 0 and 1 are the idle-detect and start cycles; BUSY from age 2
        if (m_age >= 2) begin
          if (mul_done) m_mul_fin = 1'b1;
          else if (m_age - 2 == TB_TIMEOUT - 1) begin
            m_mul_fin = 1'b1;
            m_err     = 1'b1;
          end
        end
        m_age++;
      end
      if (e_hold) begin
        m_rd[2] = m_rd[1];
        m_rd[1] = -1;
      end else begin
        m_rd[2] = m_rd[1];
        m_rd[1] = m_rd[0];
        if (e_bub) begin
          m_rd[0]  = -1;
          m_ex_mul = 1'b0;
        end else begin
          m_rd[0]  = (id_valid && id_wr_en) ? int'(id_wr_reg) : -1;
          m_ex_mul = id_valid && id_is_mul;
        end
        m_age     = 0;
        m_mul_fin = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_instr(input logic v, input int rs, input int rt, input logic urs,
                           input logic urt, input logic we, input int wr, input logic mul);
    id_valid  = v;
    id_rs     = 5'(rs);
    id_rt     = 5'(rt);
    id_use_rs = urs;
    id_use_rt = urt;
    id_wr_en  = we;
    id_wr_reg = 5'(wr);
    id_is_mul = mul;
  endtask

  task automatic nop();
    set_instr(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    m_clear();
    last_stall = 1'b0;
    clr_cnt();
    RST = 1'b0;
    mul_done = 1'b0;
    nop();
    @(posedge CLK);
    #1;

    // Reset for two cycles with an otherwise hazard-looking ID
    set_instr(1'b1, 3, 3, 1'b1, 1'b1, 1'b1, 3, 1'b1);
    tick();
    tick();
    RST = 1'b1;

    // Independent stream: reads r1/r2, writes r8..r15
    clr_cnt();
    for (int i = 0; i < 8; i++) begin
      set_instr(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 8 + i, 1'b0);
      tick();
    end
    chk_n("indep_stalls", n_stall, 0);
    nop();
    repeat (3) tick();

    // ADD r3 then dependent SUB rs=r3
    set_instr(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    tick();
    clr_cnt();
    set_instr(1'b1, 3, 4, 1'b1, 1'b1, 1'b1, 7, 1'b0);
    repeat (5) tick();
    chk_n("raw_stalls", n_stall, (TB_WB_BYPASS != 0) ? 2 : 3);
    chk_n("raw_bubbles", n_bub, (TB_WB_BYPASS != 0) ? 2 : 3);
    nop();
    repeat (3) tick();

    // Writer of r0 followed by reader of r0
    set_instr(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    tick();
    clr_cnt();
    set_instr(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 9, 1'b0);
    repeat (4) tick();
    chk_n("r0_stalls", n_stall, 0);
    nop();
    repeat (3) tick();

    // MUL r5, mul_done 33 cycles after mul_start
    set_instr(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 5, 1'b1);
    tick();
    nop();
    clr_cnt();
    for (int j = 0; j < 40; j++) begin
      mul_done = (j == 34);
      tick();
    end
    mul_done = 1'b0;
    chk_n("mul_hold_cycles", n_hold, 35);
    chk_n("mul_start_pulses", n_start, 1);

    // MUL r6 with no mul_done: timeout after 40 BUSY cycles
    set_instr(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 6, 1'b1);
    tick();
    nop();
    clr_cnt();
    repeat (48) tick();
    chk_n("timeout_hold_cycles", n_hold, 42);
    chk("timeout_err", mul_err, 1'b1);

    // Reset during BUSY
    set_instr(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 6, 1'b1);
    tick();
    nop();
    repeat (5) tick();
    RST = 1'b0;
    tick();
    RST = 1'b1;
    #4;
    chk("rst_busy_hold", ex_hold, 1'b0);
    chk("rst_busy_err", mul_err, 1'b0);
    #1;
    @(posedge CLK);
    #1;
    tick();

    // Random pipeline traffic; ID only advances when not stalled
    for (int k = 0; k < 800; k++) begin
      if (!last_stall) begin
        set_instr($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7),
                  $urandom_range(0, 9) == 0);
      end
      mul_done = ($urandom_range(0, 7) == 0);
      RST = ($urandom_range(0, 249) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
